// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite renderer.
// Contents: attribute entry layout, FSM state encoding, line geometry.
package sprite_pkg;

  localparam int unsigned LINE_W    = 640;
  localparam int unsigned SPRITE_W  = 16;
  localparam int unsigned LAST_LINE = 524;
  localparam int unsigned ATTR_W    = 32;

  // Attribute word: [31] enable, [30:26] reserved, [25] hflip,
  // [24:19] frame, [18:10] y, [9:0] x.
  typedef struct packed {
    logic       enable;
    logic [4:0] rsvd;
    logic       hflip;
    logic [5:0] frame;
    logic [8:0] y;
    logic [9:0] x;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    WAIT,
    LOAD,
    DRAW,
    DONE
  } sprite_state_e;

endpackage

// File: rtl/sprite_attr_ram.sv
// Sprite attribute register file: NUM_SPRITES x 32, one write port,
// one asynchronous read port, whole table cleared on reset.
// Ports: clk, reset_n, we/waddr/wdata (write), raddr/rdata (read).
module sprite_attr_ram
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned AW          = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [ATTR_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output sprite_attr_t      rdata
);

  logic [ATTR_W-1:0] mem [NUM_SPRITES];

  // Clearing every entry on reset leaves all sprites disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_SPRITES); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = sprite_attr_t'(mem[raddr]);

endmodule

// File: rtl/sprite_engine.sv
// Per-scanline sprite renderer. On sprite_start it scans the attribute
// table from the highest index down, fetches the row of each sprite that
// covers the target line from the sprite ROM and writes its opaque pixels
// into the line buffer draw port. Lower indices are drawn last and win.
// Ports: clk, reset_n, sprite_start, vcount, attr_we/attr_addr/attr_wdata,
//        rom_addr/rom_q, addr/data/wren_pixel_draw, sprite_busy, sprite_done.
// Build option: SPRITE_HFLIP_EN enables horizontal mirroring via attr bit 25.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned SPRITE_H    = 16,
  localparam int unsigned AW         = $clog2(NUM_SPRITES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sprite_start,
  input  logic [9:0]        vcount,
  input  logic              attr_we,
  input  logic [AW-1:0]     attr_addr,
  input  logic [ATTR_W-1:0] attr_wdata,
  output logic [9:0]        rom_addr,
  input  logic [255:0]      rom_q,
  output logic [9:0]        addr_pixel_draw,
  output logic [15:0]       data_pixel_draw,
  output logic              wren_pixel_draw,
  output logic              sprite_busy,
  output logic              sprite_done
);

  sprite_state_e state_q, state_d;

  logic [9:0]    line_q, line_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [9:0]    x_q, x_d;
  logic [255:0]  row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [9:0]    rom_addr_d, addr_d;
  logic [15:0]   data_d;
  logic          wren_d, busy_d, done_d;

  sprite_attr_t  attr;
  logic [9:0]    diff;
  logic          hit;
  logic          last_idx;
  logic [10:0]   sx;
  logic [3:0]    sel;
  logic [15:0]   pix;
  logic          unused_attr;

  sprite_attr_ram #(
    .NUM_SPRITES (NUM_SPRITES),
    .AW          (AW)
  ) u_attr_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (attr_we),
    .waddr   (attr_addr),
    .wdata   (attr_wdata),
    .raddr   (idx_q),
    .rdata   (attr)
  );

  // A line above y wraps to a large unsigned difference and misses.
  assign diff        = line_q - {1'b0, attr.y};
  assign hit         = attr.enable && (diff < 10'(SPRITE_H));
  assign last_idx    = (idx_q == '0);
  assign sx          = {1'b0, x_q} + {7'b0, col_q};
  assign unused_attr = ^{attr.rsvd, attr.hflip};

`ifdef SPRITE_HFLIP_EN
  logic hflip_q, hflip_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hflip_q <= 1'b0;
    else          hflip_q <= hflip_d;
  end

  always_comb begin
    hflip_d = hflip_q;
    if (state_q == EVAL && hit) hflip_d = attr.hflip;
  end

  // 15-col is the bitwise complement of a 4-bit column.
  assign sel = hflip_q ? ~col_q : col_q;
`else
  assign sel = col_q;
`endif

  assign pix = row_q[{sel, 4'b0000} +: 16];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sprite_start) state_d = EVAL;
      EVAL: begin
        if (hit)           state_d = WAIT;
        else if (last_idx) state_d = DONE;
      end
      WAIT: state_d = LOAD;
      LOAD: state_d = DRAW;
      DRAW: if (col_q == 4'd15) state_d = last_idx ? DONE : EVAL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and next output values
  always_comb begin
    line_d     = line_q;
    idx_d      = idx_q;
    x_d        = x_q;
    row_d      = row_q;
    col_d      = col_q;
    rom_addr_d = rom_addr;
    addr_d     = addr_pixel_draw;
    data_d     = data_pixel_draw;
    wren_d     = 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (sprite_start) begin
          line_d = (vcount == 10'(LAST_LINE)) ? 10'd0 : vcount + 10'd1;
          idx_d  = AW'(NUM_SPRITES - 1);
        end
      end
      EVAL: begin
        if (hit) begin
          rom_addr_d = {attr.frame, diff[3:0]};
          x_d        = attr.x;
        end else if (!last_idx) begin
          idx_d = idx_q - AW'(1);
        end
      end
      LOAD: begin
        row_d = rom_q;
        col_d = 4'd0;
      end
      DRAW: begin
        col_d = col_q + 4'd1;
        if (pix[0] && (sx < 11'(LINE_W))) begin
          wren_d = 1'b1;
          addr_d = sx[9:0];
          data_d = pix;
        end
        if (col_q == 4'd15 && !last_idx) idx_d = idx_q - AW'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q          <= '0;
      idx_q           <= '0;
      x_q             <= '0;
      row_q           <= '0;
      col_q           <= '0;
      rom_addr        <= '0;
      addr_pixel_draw <= '0;
      data_pixel_draw <= '0;
      wren_pixel_draw <= 1'b0;
      sprite_busy     <= 1'b0;
      sprite_done     <= 1'b0;
    end else begin
      line_q          <= line_d;
      idx_q           <= idx_d;
      x_q             <= x_d;
      row_q           <= row_d;
      col_q           <= col_d;
      rom_addr        <= rom_addr_d;
      addr_pixel_draw <= addr_d;
      data_pixel_draw <= data_d;
      wren_pixel_draw <= wren_d;
      sprite_busy     <= busy_d;
      sprite_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: expected pixel writes are queued
// before each line starts; a negedge monitor pops and compares them.
module tb_sprite_engine;

`ifdef SPRITE_HFLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sprite_start;
  logic [9:0]   vcount;
  logic         attr_we;
  logic [3:0]   attr_addr;
  logic [31:0]  attr_wdata;
  logic [9:0]   rom_addr;
  logic [255:0] rom_q;
  logic [9:0]   addr_pixel_draw;
  logic [15:0]  data_pixel_draw;
  logic         wren_pixel_draw;
  logic         sprite_busy;
  logic         sprite_done;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int rom_mode = 0;
  logic [15:0] first_data;
  logic [15:0] lb [1024];
  logic [25:0] exp_q [$];

  sprite_engine #(.NUM_SPRITES(16), .SPRITE_H(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sprite_start    (sprite_start),
    .vcount          (vcount),
    .attr_we         (attr_we),
    .attr_addr       (attr_addr),
    .attr_wdata      (attr_wdata),
    .rom_addr        (rom_addr),
    .rom_q           (rom_q),
    .addr_pixel_draw (addr_pixel_draw),
    .data_pixel_draw (data_pixel_draw),
    .wren_pixel_draw (wren_pixel_draw),
    .sprite_busy     (sprite_busy),
    .sprite_done     (sprite_done)
  );

  always #5 clk = ~clk;

  // ROM pixel: {address, column, 1, opaque}; mode 1 makes odd columns clear.
  function automatic logic opq(input int c);
    return (rom_mode == 0) ? 1'b1 : ((c % 2) == 0);
  endfunction

  function automatic logic [15:0] pix(input logic [9:0] a, input int c);
    return {a, 4'(c), 1'b1, opq(c)};
  endfunction

  function automatic logic [255:0] rom_row(input logic [9:0] a);
    logic [255:0] r;
    for (int c = 0; c < 16; c++) r[16*c +: 16] = pix(a, c);
    return r;
  endfunction

  // Synchronous ROM: one registered stage after rom_addr.
  always @(posedge clk) rom_q <= rom_row(rom_addr);

  function automatic logic [31:0] mk(input int x, input int y, input int fr,
                                     input bit hf, input bit en);
    return {en, 5'b0, hf, 6'(fr), 9'(y), 10'(x)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_attr(input int idx, input logic [31:0] w);
    @(negedge clk);
    attr_we = 1'b1; attr_addr = 4'(idx); attr_wdata = w;
    @(negedge clk);
    attr_we = 1'b0;
  endtask

  // Queue the writes one sprite row should produce.
  task automatic exp_sprite(input int x, input logic [9:0] ra, input bit flip);
    for (int c = 0; c < 16; c++) begin
      int src;
      src = (flip && FLIP_EN) ? 15 - c : c;
      if ((x + c) < 640 && opq(src)) exp_q.push_back({10'(x + c), pix(ra, src)});
    end
  endtask

  // Pulse start, then check done timing, busy window, and drained scoreboard.
  task automatic run_line(input string name, input int vc, input int exp_done);
    int k;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    vcount = 10'(vc); sprite_start = 1'b1; wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    sprite_start = 1'b0;
    k = 1; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && k < 1000) begin
      if (sprite_done) seen = 1'b1;
      else begin
        if (!sprite_busy) busy_ok = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    chk({name, "_done_cycle"}, 32'(k), 32'(exp_done));
    chk({name, "_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(sprite_done), 32'd0);
    chk({name, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: compare each draw-port write against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sprite_done) done_cnt++;
      if (wren_pixel_draw) begin
        logic [25:0] e;
        lb[addr_pixel_draw] = data_pixel_draw;
        if (wr_cnt == 0) first_data = data_pixel_draw;
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected addr=%0d data=0x%0h", addr_pixel_draw, data_pixel_draw);
        end else begin
          e = exp_q.pop_front();
          if (e !== {addr_pixel_draw, data_pixel_draw}) begin
            errors++;
            $display("FAIL write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                     addr_pixel_draw, data_pixel_draw, e[25:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    int k;
    reset_n = 1'b0; sprite_start = 1'b0; vcount = '0;
    attr_we = 1'b0; attr_addr = '0; attr_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(wren_pixel_draw), 32'd0);
    chk("rst_busy", 32'(sprite_busy), 32'd0);
    chk("rst_done", 32'(sprite_done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_addr", 32'(addr_pixel_draw), 32'd0);
    chk("rst_data", 32'(data_pixel_draw), 32'd0);
    reset_n = 1'b1;

    // No sprites enabled
    run_line("empty", 10, 17);
    chk("empty_writes", 32'(wr_cnt), 32'd0);

    // Sprite 3 covering line 53, row 3 of frame 2
    wr_attr(3, mk(100, 50, 2, 1'b0, 1'b1));
    exp_sprite(100, 10'h023, 1'b0);
    run_line("basic", 52, 35);
    chk("basic_rom_addr", 32'(rom_addr), 32'h023);
    chk("basic_writes", 32'(wr_cnt), 32'd16);

    // Right-edge clipping, then transparency
    wr_attr(3, mk(630, 50, 2, 1'b0, 1'b1));
    exp_sprite(630, 10'h023, 1'b0);
    run_line("clip", 52, 35);
    chk("clip_writes", 32'(wr_cnt), 32'd10);
    rom_mode = 1;
    exp_sprite(630, 10'h023, 1'b0);
    run_line("transp", 52, 35);
    chk("transp_writes", 32'(wr_cnt), 32'd5);
    rom_mode = 0;

    // Overlap at line 0 (vcount wraps): sprite 1 first, sprite 0 on top
    wr_attr(3, 32'd0);
    wr_attr(1, mk(200, 0, 5, 1'b0, 1'b1));
    wr_attr(0, mk(200, 0, 6, 1'b0, 1'b1));
    exp_sprite(200, 10'h050, 1'b0);
    exp_sprite(200, 10'h060, 1'b0);
    run_line("prio", 524, 53);
    chk("prio_writes", 32'(wr_cnt), 32'd32);
    chk("prio_top_pixel", 32'(lb[200]), 32'({10'h060, 4'd0, 2'b11}));
    chk("prio_rom_addr", 32'(rom_addr), 32'h060);

    // Row 9 selection
    wr_attr(0, 32'd0);
    wr_attr(1, 32'd0);
    wr_attr(2, mk(300, 470, 1, 1'b0, 1'b1));
    exp_sprite(300, 10'h019, 1'b0);
    run_line("row9", 478, 35);
    chk("row9_rom_addr", 32'(rom_addr), 32'h019);

    // Line above y misses
    wr_attr(2, mk(300, 50, 1, 1'b0, 1'b1));
    run_line("above", 40, 17);
    chk("above_writes", 32'(wr_cnt), 32'd0);
    chk("above_rom_addr", 32'(rom_addr), 32'h019);

    // Horizontal flip request
    wr_attr(2, mk(10, 50, 4, 1'b1, 1'b1));
    exp_sprite(10, 10'h041, 1'b1);
    run_line("flip", 50, 35);
    chk("flip_first", 32'(first_data),
        32'({10'h041, (FLIP_EN ? 4'd15 : 4'd0), 2'b11}));

    // Reset during DRAW
    exp_sprite(10, 10'h041, 1'b1);
    @(negedge clk);
    vcount = 10'd50; sprite_start = 1'b1; wr_cnt = 0;
    @(negedge clk);
    sprite_start = 1'b0;
    k = 0;
    while (!wren_pixel_draw && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_draw_reached", 32'(k < 200), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(wren_pixel_draw), 32'd0);
    chk("mid_rst_busy", 32'(sprite_busy), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_line("post_rst", 50, 17);
    chk("post_rst_writes", 32'(wr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
